mem_bus_arbiter: RTL and testbench

Two-requester arbiter that shares one single-ported memory between the core's instruction-fetch port and its data (load/store) port. It sits between the core's `stb`/`ack` memory interfaces and a unified memory or bus slave. It serialises requests, holds the downstream request stable until acknowledged, and routes the response back to the granted requester. A watchdog aborts transfers that are never acknowledged.

---
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported memory between an instruction-fetch port (I, read
// only) and a data port (D, load/store). Requests are accepted only from IDLE. The downstream
// request is registered and held stable until acknowledged. The response is routed back to the
// granted port. A watchdog aborts a transfer that is never acknowledged.
//
// Configuration macro:
//   ARB_RR_EN  defined   -> round-robin on contention (the port not granted last time wins)
//              undefined -> fixed priority, D beats I
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   i_i_stb, i_i_addr             fetch request and address
//   o_i_data, o_i_ack, o_i_err    fetch response, completion, watchdog abort
//   i_d_stb, i_d_wr_en            data request and direction (1 = write)
//   i_d_addr, i_d_wdata           data address and store data
//   o_d_data, o_d_ack, o_d_err    data response, completion, watchdog abort
//   o_m_stb, o_m_wr_en            downstream request and write enable
//   o_m_addr, o_m_wdata           downstream address and write data
//   i_m_data, i_m_ack             downstream read data and acknowledge
//   o_grant                       01 = I granted, 10 = D granted, 00 = idle
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_i_stb,
    input  logic [31:0] i_i_addr,
    output logic [31:0] o_i_data,
    output logic        o_i_ack,
    output logic        o_i_err,
    input  logic        i_d_stb,
    input  logic        i_d_wr_en,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic [31:0] o_d_data,
    output logic        o_d_ack,
    output logic        o_d_err,
    output logic        o_m_stb,
    output logic        o_m_wr_en,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_wdata,
    input  logic [31:0] i_m_data,
    input  logic        i_m_ack,
    output logic [1:0]  o_grant
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
    localparam bit WdogEn = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            wr_en_q, wr_en_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_grant_q, last_grant_d;  // 0 = I, 1 = D

    logic gnt_i;
    logic gnt_d;
    logic timeout_hit;
    logic pick_d;

    assign gnt_i       = (state_q == StGntI);
    assign gnt_d       = (state_q == StGntD);
    assign timeout_hit = WdogEn && (cnt_q == TimeoutCnt);

    // D wins when it requests, unless round-robin says I is owed a turn.
`ifdef ARB_RR_EN
    assign pick_d = i_d_stb && (!i_i_stb || !last_grant_q);
`else
    assign pick_d = i_d_stb;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_en_d      = wr_en_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pick_d) begin
                    state_d      = StGntD;
                    addr_d       = i_d_addr;
                    wdata_d      = i_d_wdata;
                    wr_en_d      = i_d_wr_en;
                    last_grant_d = 1'b1;
                end else if (i_i_stb) begin
                    state_d      = StGntI;
                    addr_d       = i_i_addr;
                    wdata_d      = '0;
                    wr_en_d      = 1'b0;
                    last_grant_d = 1'b0;
                end
            end
            StGntI, StGntD: begin
                if (i_m_ack || timeout_hit) begin
                    state_d = StIdle;
                end else if (WdogEn) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_en_q      <= 1'b0;
            cnt_q        <= '0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_en_q      <= wr_en_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Responses are combinational from the memory side; an ack on the watchdog cycle wins.
    always_comb begin
        o_i_ack   = gnt_i && i_m_ack;
        o_d_ack   = gnt_d && i_m_ack;
        o_i_err   = gnt_i && !i_m_ack && timeout_hit;
        o_d_err   = gnt_d && !i_m_ack && timeout_hit;
        o_i_data  = o_i_ack ? i_m_data : 32'h0;
        o_d_data  = (o_d_ack && !wr_en_q) ? i_m_data : 32'h0;
        o_m_stb   = gnt_i || gnt_d;
        o_m_wr_en = wr_en_q;
        o_m_addr  = addr_q;
        o_m_wdata = wdata_q;
        o_grant   = {gnt_d, gnt_i};
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of single transfers, hand sequences for contention,
// watchdog, reset and spurious ack, then randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_i_stb;
    logic [31:0] i_i_addr;
    logic [31:0] o_i_data;
    logic        o_i_ack;
    logic        o_i_err;
    logic        i_d_stb;
    logic        i_d_wr_en;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic [31:0] o_d_data;
    logic        o_d_ack;
    logic        o_d_err;
    logic        o_m_stb;
    logic        o_m_wr_en;
    logic [31:0] o_m_addr;
    logic [31:0] o_m_wdata;
    logic [31:0] i_m_data;
    logic        i_m_ack;
    logic [1:0]  o_grant;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_i_stb   (i_i_stb),
        .i_i_addr  (i_i_addr),
        .o_i_data  (o_i_data),
        .o_i_ack   (o_i_ack),
        .o_i_err   (o_i_err),
        .i_d_stb   (i_d_stb),
        .i_d_wr_en (i_d_wr_en),
        .i_d_addr  (i_d_addr),
        .i_d_wdata (i_d_wdata),
        .o_d_data  (o_d_data),
        .o_d_ack   (o_d_ack),
        .o_d_err   (o_d_err),
        .o_m_stb   (o_m_stb),
        .o_m_wr_en (o_m_wr_en),
        .o_m_addr  (o_m_addr),
        .o_m_wdata (o_m_wdata),
        .i_m_data  (i_m_data),
        .i_m_ack   (i_m_ack),
        .o_grant   (o_grant)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are driven just after a rising edge and outputs are checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        i_i_stb   = 1'b0;
        i_i_addr  = 32'h0;
        i_d_stb   = 1'b0;
        i_d_wr_en = 1'b0;
        i_d_addr  = 32'h0;
        i_d_wdata = 32'h0;
        i_m_data  = 32'h0;
        i_m_ack   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- transaction-level reference model ----------------
    logic        mb_busy;
    logic        mb_port;   // 0 = I, 1 = D
    logic        mb_wr;
    logic [31:0] mb_addr;
    logic [31:0] mb_wdata;
    int          mb_age;    // cycles spent waiting in the current grant
    logic        mb_last;   // port granted most recently

    task automatic model_reset();
        mb_busy  = 1'b0;
        mb_port  = 1'b0;
        mb_wr    = 1'b0;
        mb_addr  = 32'h0;
        mb_wdata = 32'h0;
        mb_age   = 0;
        mb_last  = 1'b0;
    endtask

    task automatic model_check();
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        ack   = mb_busy && i_m_ack;
        err   = mb_busy && !i_m_ack && (mb_age == TO);
        rdata = (ack && !mb_wr) ? i_m_data : 32'h0;
        chk("rnd_m_stb",   {31'h0, o_m_stb}, {31'h0, mb_busy});
        chk("rnd_grant",   {30'h0, o_grant},
            mb_busy ? (mb_port ? 32'd2 : 32'd1) : 32'd0);
        chk("rnd_m_addr",  o_m_addr, mb_addr);
        chk("rnd_m_wdata", o_m_wdata, mb_wdata);
        chk("rnd_m_wr_en", {31'h0, o_m_wr_en}, {31'h0, mb_wr});
        chk("rnd_i_ack",   {31'h0, o_i_ack}, {31'h0, ack && !mb_port});
        chk("rnd_d_ack",   {31'h0, o_d_ack}, {31'h0, ack && mb_port});
        chk("rnd_i_err",   {31'h0, o_i_err}, {31'h0, err && !mb_port});
        chk("rnd_d_err",   {31'h0, o_d_err}, {31'h0, err && mb_port});
        chk("rnd_i_data",  o_i_data, mb_port ? 32'h0 : rdata);
        chk("rnd_d_data",  o_d_data, mb_port ? rdata : 32'h0);
    endtask

    task automatic model_step();
        logic win_d;
        if (rst) begin
            model_reset();
        end else if (!mb_busy) begin
            if (i_i_stb || i_d_stb) begin
`ifdef ARB_RR_EN
                win_d = i_d_stb && (!i_i_stb || mb_last == 1'b0);
`else
                win_d = i_d_stb;
`endif
                mb_busy  = 1'b1;
                mb_port  = win_d;
                mb_last  = win_d;
                mb_addr  = win_d ? i_d_addr : i_i_addr;
                mb_wr    = win_d ? i_d_wr_en : 1'b0;
                mb_wdata = win_d ? i_d_wdata : 32'h0;
                mb_age   = 0;
            end
        end else if (i_m_ack || mb_age == TO) begin
            mb_busy = 1'b0;
        end else begin
            mb_age++;
        end
    endtask

    // ---------------- directed transfer table ----------------
    typedef struct {
        logic        istb;
        logic        dstb;
        logic        dwr;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] rdata;
        int          wait_n;
        logic [1:0]  exp_grant;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_wr;
        logic [31:0] exp_idata;
        logic [31:0] exp_ddata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        idle_inputs();
        rst = 1'b1;

        // fetch 0x100, immediate ack
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 0,
                    2'b01, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0};
        // store 0x2000, 3 wait cycles; write returns 0 data
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h2000, 32'h12345678, 32'hCAFEF00D, 3,
                    2'b10, 32'h2000, 32'h12345678, 1'b1, 32'h0, 32'h0};
        // load, 1 wait cycle
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h3004, 32'h77, 32'hA5A50001, 1,
                    2'b10, 32'h3004, 32'h77, 1'b0, 32'h0, 32'hA5A50001};
        // fetch while D write fields are set but D is not requesting
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h4, 32'hFFFF0000, 32'h99, 32'h12340000, 2,
                    2'b01, 32'h4, 32'h0, 1'b0, 32'h12340000, 32'h0};
        // contention after an I grant: D wins in both modes
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h500, 32'h600, 32'h11, 32'h55, 0,
                    2'b10, 32'h600, 32'h11, 1'b0, 32'h0, 32'h55};
        // contention after a D grant
`ifdef ARB_RR_EN
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h700, 32'h800, 32'h22, 32'h66, 0,
                    2'b01, 32'h700, 32'h0, 1'b0, 32'h66, 32'h0};
`else
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h700, 32'h800, 32'h22, 32'h66, 0,
                    2'b10, 32'h800, 32'h22, 1'b0, 32'h0, 32'h66};
`endif

        // ---- reset state ----
        do_reset();
        settle();
        chk("rst_m_stb",   {31'h0, o_m_stb}, 32'h0);
        chk("rst_grant",   {30'h0, o_grant}, 32'h0);
        chk("rst_m_addr",  o_m_addr, 32'h0);
        chk("rst_m_wdata", o_m_wdata, 32'h0);
        chk("rst_m_wr_en", {31'h0, o_m_wr_en}, 32'h0);
        chk("rst_acks",    {30'h0, o_i_ack, o_d_ack}, 32'h0);
        chk("rst_errs",    {30'h0, o_i_err, o_d_err}, 32'h0);
        chk("rst_i_data",  o_i_data, 32'h0);
        chk("rst_d_data",  o_d_data, 32'h0);

        // ---- table ----
        for (int v = 0; v < 6; v++) begin
            i_i_stb   = vecs[v].istb;
            i_d_stb   = vecs[v].dstb;
            i_d_wr_en = vecs[v].dwr;
            i_i_addr  = vecs[v].iaddr;
            i_d_addr  = vecs[v].daddr;
            i_d_wdata = vecs[v].dwdata;
            i_m_ack   = 1'b0;
            settle();
            chk("tbl_idle_stb", {31'h0, o_m_stb}, 32'h0);
            tick();
            // requester changes during the grant must be ignored
            i_i_stb   = 1'b0;
            i_d_stb   = 1'b0;
            i_i_addr  = 32'hBAD00000;
            i_d_addr  = 32'hBAD00001;
            i_d_wdata = 32'hBAD00002;
            i_d_wr_en = ~vecs[v].dwr;
            for (int k = 0; k <= vecs[v].wait_n; k++) begin
                i_m_ack  = (k == vecs[v].wait_n);
                i_m_data = vecs[v].rdata;
                settle();
                chk("tbl_m_stb",   {31'h0, o_m_stb}, 32'h1);
                chk("tbl_grant",   {30'h0, o_grant}, {30'h0, vecs[v].exp_grant});
                chk("tbl_m_addr",  o_m_addr, vecs[v].exp_addr);
                chk("tbl_m_wdata", o_m_wdata, vecs[v].exp_wdata);
                chk("tbl_m_wr_en", {31'h0, o_m_wr_en}, {31'h0, vecs[v].exp_wr});
                if (k == vecs[v].wait_n) begin
                    chk("tbl_i_ack",  {31'h0, o_i_ack}, {31'h0, vecs[v].exp_grant[0]});
                    chk("tbl_d_ack",  {31'h0, o_d_ack}, {31'h0, vecs[v].exp_grant[1]});
                    chk("tbl_i_data", o_i_data, vecs[v].exp_idata);
                    chk("tbl_d_data", o_d_data, vecs[v].exp_ddata);
                end else begin
                    chk("tbl_wait_acks", {30'h0, o_i_ack, o_d_ack}, 32'h0);
                end
                tick();
            end
            i_m_ack = 1'b0;
            settle();
            chk("tbl_post_stb",   {31'h0, o_m_stb}, 32'h0);
            chk("tbl_post_grant", {30'h0, o_grant}, 32'h0);
        end

        // ---- contention: both held high, immediate acks, 4 transfers ----
        begin
            logic [1:0] exp_seq [4];
`ifdef ARB_RR_EN
            exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
            exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
            do_reset();
            i_i_stb  = 1'b1;
            i_d_stb  = 1'b1;
            i_i_addr = 32'hA0;
            i_d_addr = 32'hB0;
            i_m_ack  = 1'b1;
            i_m_data = 32'h5A5A5A5A;
            for (int t = 0; t < 8; t++) begin
                settle();
                if (t % 2 == 1) begin
                    chk("cont_grant", {30'h0, o_grant}, {30'h0, exp_seq[t / 2]});
                    chk("cont_acks",  {30'h0, o_d_ack, o_i_ack}, {30'h0, exp_seq[t / 2]});
                end else begin
                    chk("cont_idle", {30'h0, o_grant}, 32'h0);
                end
                tick();
            end
            idle_inputs();
        end

        // ---- watchdog: never ack, then ack exactly on the timeout cycle ----
        for (int rep = 0; rep < 2; rep++) begin
            do_reset();
            i_d_stb  = 1'b1;
            i_d_addr = 32'h40;
            settle();
            tick();
            i_d_stb = 1'b0;
            for (int k = 1; k <= TO + 1; k++) begin
                i_m_ack  = (rep == 1) && (k == TO + 1);
                i_m_data = 32'hFEED0000;
                settle();
                chk("wd_m_stb", {31'h0, o_m_stb}, 32'h1);
                if (k == TO + 1) begin
                    chk("wd_err_edge", {31'h0, o_d_err}, (rep == 0) ? 32'h1 : 32'h0);
                    chk("wd_ack_edge", {31'h0, o_d_ack}, (rep == 0) ? 32'h0 : 32'h1);
                    chk("wd_data_edge", o_d_data, (rep == 0) ? 32'h0 : 32'hFEED0000);
                end else begin
                    chk("wd_early", {30'h0, o_d_err, o_d_ack}, 32'h0);
                end
                tick();
            end
            i_m_ack = 1'b0;
            settle();
            chk("wd_idle_stb", {31'h0, o_m_stb}, 32'h0);
            chk("wd_idle_err", {31'h0, o_d_err}, 32'h0);
        end

        // ---- reset mid-transfer, then a late ack ----
        do_reset();
        i_i_stb  = 1'b1;
        i_i_addr = 32'h900;
        settle();
        tick();
        i_i_stb = 1'b0;
        settle();
        chk("rmid_grant_pre", {30'h0, o_grant}, 32'h1);
        tick();
        rst = 1'b1;
        settle();
        chk("rmid_no_ack", {31'h0, o_i_ack}, 32'h0);
        tick();
        rst      = 1'b0;
        i_m_ack  = 1'b1;
        i_m_data = 32'h13579BDF;
        settle();
        chk("rmid_m_stb",  {31'h0, o_m_stb}, 32'h0);
        chk("rmid_grant",  {30'h0, o_grant}, 32'h0);
        chk("rmid_i_ack",  {31'h0, o_i_ack}, 32'h0);
        chk("rmid_m_addr", o_m_addr, 32'h0);
        tick();
        i_m_ack = 1'b0;

        // ---- spurious ack while idle ----
        i_m_ack  = 1'b1;
        i_m_data = 32'hFFFFFFFF;
        settle();
        chk("spur_acks", {30'h0, o_i_ack, o_d_ack}, 32'h0);
        chk("spur_data", o_i_data | o_d_data, 32'h0);
        tick();
        i_m_ack = 1'b0;
        settle();
        chk("spur_state", {29'h0, o_m_stb, o_grant}, 32'h0);

        // ---- randomized traffic against the model ----
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            int ack_pct;
            ack_pct   = ((c / 250) % 2 == 1) ? 5 : 50;
            rst       = ($urandom_range(0, 99) == 0);
            i_i_stb   = 1'($urandom_range(0, 1));
            i_d_stb   = 1'($urandom_range(0, 1));
            i_d_wr_en = 1'($urandom_range(0, 1));
            i_i_addr  = $urandom;
            i_d_addr  = $urandom;
            i_d_wdata = $urandom;
            i_m_data  = $urandom;
            i_m_ack   = ($urandom_range(0, 99) < ack_pct);
            settle();
            model_check();
            model_step();
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
